// File: rtl/ahb_slave_mux.sv
// AHB slave-side response mux with a built-in default slave for unmapped transfers.
// Define AHB_MUX_ERR_COUNT_EN to add the saturating ERR_COUNT port.
module ahb_slave_mux #(
  parameter int DATA_WIDTH   = 32,
  parameter int NO_OF_SLAVES = 2
) (
  input  logic                               HCLK,
  input  logic                               HRESET,
  input  logic [NO_OF_SLAVES-1:0]            HSEL,
  input  logic [1:0]                         HTRANS,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NO_OF_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NO_OF_SLAVES-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]              HRDATA,
  output logic                               HREADY,
  output logic                               HRESP
`ifdef AHB_MUX_ERR_COUNT_EN
  ,
  output logic [7:0]                         ERR_COUNT
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } dflt_state_e;

  dflt_state_e               state_q, state_d;
  logic [NO_OF_SLAVES-1:0]   sel_q, sel_d;
  logic [NO_OF_SLAVES-1:0]   hsel_low;
  logic [DATA_WIDTH-1:0]     rdata_mux;
  logic                      ready_mux, resp_mux;
  logic                      dflt_ready, dflt_resp;
  logic                      sel_any, hready, trans_active, err_start;

  // Lowest-index set bit wins if the decoder ever asserts more than one select.
  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    hsel_low = '0;
    for (int i = NO_OF_SLAVES - 1; i >= 0; i--) begin
      if (HSEL[i]) begin
        hsel_low    = '0;
        hsel_low[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_mux = '0;
    ready_mux = 1'b1;
    resp_mux  = 1'b0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (sel_q[i]) begin
        rdata_mux = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        ready_mux = HREADYOUT_S[i];
        resp_mux  = HRESP_S[i];
      end
    end
  end

  always_comb begin
    dflt_ready = 1'b1;
    dflt_resp  = 1'b0;
    case (state_q)
      ST_ERR1: begin dflt_ready = 1'b0; dflt_resp = 1'b1; end
      ST_ERR2: begin dflt_ready = 1'b1; dflt_resp = 1'b1; end
      default: ;
    endcase
  end

  assign sel_any = |sel_q;
  assign hready  = sel_any ? ready_mux : dflt_ready;
  assign HREADY  = hready;
  assign HRESP   = sel_any ? resp_mux  : dflt_resp;
  assign HRDATA  = sel_any ? rdata_mux : '0;

  assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
  assign err_start    = hready && (HSEL == '0) && trans_active;

  always_comb begin
    sel_d   = hready ? hsel_low : sel_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (err_start) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = err_start ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

`ifdef AHB_MUX_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_start && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign ERR_COUNT = err_cnt_q;
`endif

endmodule

// File: doc/ahb_slave_mux.md
AHB_SLAVE_MUX -- requirements
Module: AHB_Slave_Mux

Interface
Parameters:
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, read data width in bits.
REQ-002 SHALL provide parameter NO_OF_SLAVES, default 2, number of slave ports; HSEL width matches the decoder.
Ports:
REQ-003 SHALL have port HCLK  input  1  bus clock; all state changes on its rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port HSEL  input  NO_OF_SLAVES  one-hot address-phase select from the decoder; all-zero means unmapped.
REQ-006 SHALL have port HTRANS  input  2  address-phase transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 SHALL have port HRDATA_S  input  NO_OF_SLAVES*DATA_WIDTH  slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port HREADYOUT_S  input  NO_OF_SLAVES  per-slave ready.
REQ-009 SHALL have port HRESP_S  input  NO_OF_SLAVES  per-slave response, 1 = ERROR.
REQ-010 SHALL have port HRDATA  output  DATA_WIDTH  muxed read data to master.
REQ-011 SHALL have port HREADY  output  1  muxed ready, also fed back to all slaves.
REQ-012 SHALL have port HRESP  output  1  muxed response.
REQ-013 SHALL have port ERR_COUNT  output  8  default-slave error count (only with AHB_MUX_ERR_COUNT_EN).

Function
REQ-014 SHALL register the data-phase select sel_q <= HSEL on every rising edge where HREADY=1; sel_q SHALL hold while HREADY=0.
REQ-015 SHALL, if HSEL has multiple bits set, register only the lowest-index set bit.
REQ-016 SHALL, when sel_q has bit i set, drive HRDATA, HREADY and HRESP from slave i combinationally (zero added latency).
REQ-017 SHALL implement an internal default slave with an FSM of three states: IDLE, ERR1, ERR2.
REQ-018 SHALL move IDLE->ERR1 on an edge where HREADY=1, HSEL=0 and HTRANS is NONSEQ or SEQ.
REQ-019 SHALL, in ERR1, drive HREADY=0 and HRESP=1, then move to ERR2 unconditionally.
REQ-020 SHALL, in ERR2, drive HREADY=1 and HRESP=1; ERR2 SHALL re-enter ERR1 if the REQ-018 condition holds again, otherwise return to IDLE.
REQ-021 SHALL, in IDLE with sel_q=0 (unmapped IDLE/BUSY data phase or no prior transfer), drive HREADY=1 and HRESP=0 (OKAY, zero wait).
REQ-022 SHALL drive HRDATA=0 whenever sel_q=0.
REQ-023 SHALL let a mapped slave's wait states and its own two-cycle ERROR pass through unmodified.
REQ-024 SHALL support back-to-back transfers across slaves: address phase to slave B is accepted in the same cycle slave A's data phase completes.

Reset
REQ-025 SHALL, while HRESET=1, immediately force the FSM to IDLE and sel_q=0, giving HREADY=1, HRESP=0 and HRDATA=0.
REQ-026 SHALL abandon any in-progress ERR1/ERR2 or slave wait state on reset; no completion is produced.
REQ-027 SHALL reset ERR_COUNT to 0.

Configuration
REQ-028 SHALL use macro AHB_MUX_ERR_COUNT_EN; when defined, ERR_COUNT exists and increments by 1 on each ERR1 entry, saturating at 255.
REQ-029 SHALL, when AHB_MUX_ERR_COUNT_EN is undefined, omit the ERR_COUNT port and counter while keeping all other behaviour identical.

Verification
REQ-030 SHALL test read: HSEL=01 with NONSEQ, then slave0 returns HRDATA_S=0xA5A5A5A5 with HREADYOUT=1 -> HRDATA=0xA5A5A5A5, HREADY=1 and HRESP=0 one cycle after the address phase.
REQ-031 SHALL test waits: HSEL=10 with NONSEQ and slave1 holding HREADYOUT=0 for 3 cycles -> HREADY=0 for 3 cycles, sel_q held, and HSEL changes ignored until ready.
REQ-032 SHALL test unmapped access: HSEL=00 with NONSEQ -> cycle 1 gives HREADY=0, HRESP=1; cycle 2 gives HREADY=1, HRESP=1; ERR_COUNT goes 0->1.
REQ-033 SHALL test unmapped IDLE: HSEL=00 with HTRANS=IDLE -> HREADY=1, HRESP=0, HRDATA=0, and ERR_COUNT unchanged.
REQ-034 SHALL test reset mid-operation: HRESET asserted during ERR1 -> HREADY=1 and HRESP=0 asynchronously, and FSM in IDLE after release.
REQ-035 SHALL test saturation: 300 unmapped NONSEQ transfers -> ERR_COUNT=255.
